// File: rtl/cpa_pkg.sv
// cpa_pkg: shared constants and FSM state type for the CPA capture host.
// LFSR tap mask is only consumed by builds with CPA_HOST_LFSR_EN defined.
package cpa_pkg;

   localparam int unsigned AES_BLOCK_BYTES     = 16;
   localparam int unsigned SENSE_BYTES_DEFAULT = 56;
   localparam int unsigned LFSR_WIDTH          = 128;

   // Fibonacci taps 128,126,101,99 expressed as zero-based bit positions
   localparam logic [LFSR_WIDTH-1:0] LFSR_TAP_MASK =
      (128'h1 << 127) | (128'h1 << 125) | (128'h1 << 100) | (128'h1 << 98);

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_GEN_PT,
      ST_SEND_PT,
      ST_TX_WAIT,
      ST_RECV_CT,
      ST_RECV_SENSE,
      ST_NEXT,
      ST_DONE,
      ST_ERR
   } cpa_state_e;

endpackage

// File: rtl/cpa_trace_host_if.sv
// cpa_trace_host_if: byte-wide UART handshake between the trace host and its UART core.
// master = trace host, slave = UART core.
interface cpa_trace_host_if;

   logic       uart_tx_ready;
   logic       uart_tx_enable;
   logic [7:0] uart_data_to_tx;
   logic       uart_rx_ready;
   logic [7:0] uart_data_from_rx;

   modport master (
      input  uart_tx_ready,
      output uart_tx_enable,
      output uart_data_to_tx,
      input  uart_rx_ready,
      input  uart_data_from_rx
   );

   modport slave (
      output uart_tx_ready,
      input  uart_tx_enable,
      input  uart_data_to_tx,
      output uart_rx_ready,
      output uart_data_from_rx
   );

endinterface

// File: rtl/cpa_pt_lfsr.sv
// cpa_pt_lfsr: 128-bit Fibonacci plaintext LFSR with load/step control.
// Only present when CPA_HOST_LFSR_EN is defined; a zero SEED is replaced by 1.
`ifdef CPA_HOST_LFSR_EN
module cpa_pt_lfsr
   import cpa_pkg::*;
#(
   parameter logic [LFSR_WIDTH-1:0] SEED = 128'h1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_load,
   input  logic                  i_step,
   output logic [LFSR_WIDTH-1:0] o_state,
   output logic [LFSR_WIDTH-1:0] o_next
);

   localparam logic [LFSR_WIDTH-1:0] SEED_EFF = (SEED == '0) ? 128'h1 : SEED;

   logic [LFSR_WIDTH-1:0] r_state;
   logic                  w_fb;

   assign w_fb    = ^(r_state & LFSR_TAP_MASK);
   assign o_next  = {r_state[LFSR_WIDTH-2:0], w_fb};
   assign o_state = r_state;

   always_ff @(posedge clk) begin
      if (rst || i_load) begin
         r_state <= SEED_EFF;
      end else if (i_step) begin
         r_state <= o_next;
      end
   end

endmodule
`endif

// File: rtl/cpa_trace_host.sv
// cpa_trace_host: per trace sends a 16-byte plaintext, collects ciphertext and sensor bytes, with idle timeout.
// Define CPA_HOST_LFSR_EN to generate plaintexts with an on-chip LFSR instead of sampling pt_in.
module cpa_trace_host
   import cpa_pkg::*;
#(
   parameter int unsigned    NUM_TRACES     = 1000,
   parameter int unsigned    SENSE_BYTES    = SENSE_BYTES_DEFAULT,
   parameter logic [23:0]    TIMEOUT_CYCLES = 24'd12_000_000,
   parameter logic [127:0]   LFSR_SEED      = 128'h1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [127:0]            pt_in,
   cpa_trace_host_if.master        uart,
   output logic [127:0]            pt_out,
   output logic [127:0]            ct_out,
   output logic                    ct_valid,
   output logic [7:0]              sense_byte,
   output logic                    sense_valid,
   output logic [8:0]              sense_index,
   output logic [15:0]             trace_count,
   output logic                    busy,
   output logic                    done,
   output logic                    timeout_err
);

   cpa_state_e    r_state, w_state_nxt;
   logic [8:0]    r_cnt;
   logic [23:0]   r_to_cnt;
   logic          r_tx_low, r_start_d;
   logic          r_tx_en;
   logic [7:0]    r_tx_data;
   logic [127:0]  r_pt, r_ct;
   logic          r_ct_valid, r_sense_valid;
   logic [7:0]    r_sense_byte;
   logic [8:0]    r_sense_index;
   logic [15:0]   r_trace_count;
   logic          r_to_err;

   logic          w_run_start, w_tx_fire, w_rx_take, w_to_expire;
   logic          w_rx, w_to_term, w_gen_last;
   logic [127:0]  w_pt_gen;

   assign w_rx      = uart.uart_rx_ready;
   assign w_to_term = (r_to_cnt == TIMEOUT_CYCLES - 24'd1);

`ifdef CPA_HOST_LFSR_EN
   logic [127:0] w_lfsr_next, w_unused_lfsr_state;
   logic         w_unused_pt, w_gen_step;

   assign w_unused_pt = ^pt_in;
   assign w_gen_step  = (r_state == ST_GEN_PT);
   // GEN_PT spans 128 steps; the last step's successor is what lands in pt_out
   assign w_gen_last  = w_gen_step && (r_cnt[6:0] == 7'h7f);
   assign w_pt_gen    = w_lfsr_next;

   cpa_pt_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_run_start),
      .i_step  (w_gen_step),
      .o_state (w_unused_lfsr_state),
      .o_next  (w_lfsr_next)
   );
`else
   logic [127:0] w_unused_seed;

   assign w_unused_seed = LFSR_SEED;
   assign w_gen_last    = (r_state == ST_GEN_PT);
   assign w_pt_gen      = pt_in;
`endif

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_run_start = 1'b0;
      w_tx_fire   = 1'b0;
      w_rx_take   = 1'b0;
      w_to_expire = 1'b0;
      case (r_state)
         ST_IDLE: if (start) begin
            w_run_start = 1'b1;
            w_state_nxt = ST_GEN_PT;
         end
         ST_GEN_PT: if (w_gen_last) w_state_nxt = ST_SEND_PT;
         ST_SEND_PT: if (uart.uart_tx_ready) begin
            w_tx_fire   = 1'b1;
            w_state_nxt = ST_TX_WAIT;
         end
         ST_TX_WAIT: if (r_tx_low && uart.uart_tx_ready) begin
            w_state_nxt = (r_cnt == 9'(AES_BLOCK_BYTES)) ? ST_RECV_CT : ST_SEND_PT;
         end
         ST_RECV_CT: begin
            if (w_rx) begin
               w_rx_take = 1'b1;
               if (r_cnt == 9'(AES_BLOCK_BYTES - 1)) w_state_nxt = ST_RECV_SENSE;
            end else if (w_to_term) begin
               w_to_expire = 1'b1;
               w_state_nxt = ST_ERR;
            end
         end
         ST_RECV_SENSE: begin
            if (w_rx) begin
               w_rx_take = 1'b1;
               if (r_cnt == 9'(SENSE_BYTES - 1)) w_state_nxt = ST_NEXT;
            end else if (w_to_term) begin
               w_to_expire = 1'b1;
               w_state_nxt = ST_ERR;
            end
         end
         ST_NEXT: w_state_nxt = (r_trace_count == 16'(NUM_TRACES - 1)) ? ST_DONE : ST_GEN_PT;
         ST_DONE: w_state_nxt = ST_IDLE;
         ST_ERR: if (start && !r_start_d) begin
            w_run_start = 1'b1;
            w_state_nxt = ST_GEN_PT;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt         <= '0;
         r_to_cnt      <= '0;
         r_tx_low      <= 1'b0;
         r_start_d     <= 1'b0;
         r_tx_en       <= 1'b0;
         r_tx_data     <= '0;
         r_pt          <= '0;
         r_ct          <= '0;
         r_ct_valid    <= 1'b0;
         r_sense_valid <= 1'b0;
         r_sense_byte  <= '0;
         r_sense_index <= '0;
         r_trace_count <= '0;
         r_to_err      <= 1'b0;
      end else begin
         r_start_d     <= start;
         r_tx_en       <= 1'b0;
         r_ct_valid    <= 1'b0;
         r_sense_valid <= 1'b0;
         if (w_run_start) begin
            r_trace_count <= '0;
            r_to_err      <= 1'b0;
            r_cnt         <= '0;
         end
         if (w_to_expire) r_to_err <= 1'b1;
         case (r_state)
            ST_GEN_PT: begin
               if (w_gen_last) begin
                  r_pt  <= w_pt_gen;
                  r_cnt <= '0;
               end else begin
                  r_cnt <= r_cnt + 9'd1;
               end
            end
            ST_SEND_PT: if (w_tx_fire) begin
               r_tx_en   <= 1'b1;
               r_tx_data <= r_pt[{r_cnt[3:0], 3'b000} +: 8];
               r_cnt     <= r_cnt + 9'd1;
               r_tx_low  <= 1'b0;
            end
            ST_TX_WAIT: begin
               if (!uart.uart_tx_ready) r_tx_low <= 1'b1;
               if (w_state_nxt == ST_RECV_CT) begin
                  r_cnt    <= '0;
                  r_to_cnt <= '0;
               end
            end
            ST_RECV_CT: begin
               r_to_cnt <= w_rx ? '0 : r_to_cnt + 24'd1;
               if (w_rx_take) begin
                  r_ct[{r_cnt[3:0], 3'b000} +: 8] <= uart.uart_data_from_rx;
                  if (w_state_nxt == ST_RECV_SENSE) begin
                     r_ct_valid <= 1'b1;
                     r_cnt      <= '0;
                  end else begin
                     r_cnt <= r_cnt + 9'd1;
                  end
               end
            end
            ST_RECV_SENSE: begin
               r_to_cnt <= w_rx ? '0 : r_to_cnt + 24'd1;
               if (w_rx_take) begin
                  r_sense_byte  <= uart.uart_data_from_rx;
                  r_sense_index <= r_cnt;
                  r_sense_valid <= 1'b1;
                  r_cnt         <= (w_state_nxt == ST_NEXT) ? '0 : r_cnt + 9'd1;
               end
            end
            ST_NEXT: r_trace_count <= r_trace_count + 16'd1;
            default: ;
         endcase
      end
   end

   assign uart.uart_tx_enable  = r_tx_en;
   assign uart.uart_data_to_tx = r_tx_data;
   assign pt_out      = r_pt;
   assign ct_out      = r_ct;
   assign ct_valid    = r_ct_valid;
   assign sense_byte  = r_sense_byte;
   assign sense_valid = r_sense_valid;
   assign sense_index = r_sense_index;
   assign trace_count = r_trace_count;
   assign timeout_err = r_to_err;
   assign busy        = !((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR));
   assign done        = (r_state == ST_DONE);

endmodule

// File: tb/tb_cpa_trace_host.sv
// tb_cpa_trace_host: randomized bench with a UART emulator and a plaintext/ciphertext/sensor reference model.
// Works in both builds; with CPA_HOST_LFSR_EN defined the expected plaintexts come from a bench-side LFSR.
module tb_cpa_trace_host;

   localparam int unsigned  NT      = 3;
   localparam int unsigned  SB      = 56;
   localparam int unsigned  TO      = 100;
   localparam logic [127:0] TB_SEED = 128'h0;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [127:0] pt_in = '0;
   logic [127:0] pt_out, ct_out;
   logic         ct_valid, sense_valid, busy, done, timeout_err;
   logic [7:0]   sense_byte;
   logic [8:0]   sense_index;
   logic [15:0]  trace_count;

   cpa_trace_host_if ifc ();

   cpa_trace_host #(
      .NUM_TRACES     (NT),
      .SENSE_BYTES    (SB),
      .TIMEOUT_CYCLES (24'(TO)),
      .LFSR_SEED      (TB_SEED)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .pt_in       (pt_in),
      .uart        (ifc),
      .pt_out      (pt_out),
      .ct_out      (ct_out),
      .ct_valid    (ct_valid),
      .sense_byte  (sense_byte),
      .sense_valid (sense_valid),
      .sense_index (sense_index),
      .trace_count (trace_count),
      .busy        (busy),
      .done        (done),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // UART transmitter emulator: accepts a byte on the strobe, stays busy a few cycles
   logic [7:0]  txq[$];
   bit          tx_busy   = 1'b0;
   bit          hold_mode = 1'b0;
   int unsigned tx_early  = 0;

   initial begin
      ifc.uart_tx_ready = 1'b1;
      forever begin
         @(negedge clk);
         if (ifc.uart_tx_enable) begin
            tx_busy = 1'b1;
            txq.push_back(ifc.uart_data_to_tx);
            if (hold_mode) begin
               repeat (10) begin
                  @(negedge clk);
                  if (ifc.uart_tx_enable) tx_early++;
               end
            end
            ifc.uart_tx_ready = 1'b0;
            repeat ($urandom_range(1, 3)) begin
               @(negedge clk);
               if (ifc.uart_tx_enable) tx_early++;
            end
            ifc.uart_tx_ready = 1'b1;
            tx_busy = 1'b0;
         end
      end
   end

   int unsigned ct_pulses = 0;
   int unsigned done_pulses = 0;

   initial forever begin
      @(negedge clk);
      if (ct_valid) ct_pulses++;
      if (done) done_pulses++;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [127:0] model_lfsr;
   logic [127:0] cur_pt_in;

`ifdef CPA_HOST_LFSR_EN
   function automatic logic [127:0] lfsr_step128(input logic [127:0] s);
      logic [127:0] v;
      v = s;
      for (int i = 0; i < 128; i++) v = {v[126:0], v[127] ^ v[125] ^ v[100] ^ v[98]};
      return v;
   endfunction
`endif

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic model_run_start();
      model_lfsr = (TB_SEED == '0) ? 128'h1 : TB_SEED;
   endtask

   task automatic next_expected_pt(output logic [127:0] p);
`ifdef CPA_HOST_LFSR_EN
      model_lfsr = lfsr_step128(model_lfsr);
      p = model_lfsr;
`else
      p = cur_pt_in;
`endif
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic send_rx(input logic [7:0] b);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      @(negedge clk);
      ifc.uart_rx_ready = 1'b1;
      ifc.uart_data_from_rx = b;
      @(negedge clk);
      ifc.uart_rx_ready = 1'b0;
   endtask

   task automatic recv_tx_block(input string tag, input logic [127:0] exp_pt);
      for (int i = 0; i < 16; i++) begin
         int unsigned w = 0;
         while (txq.size() == 0 && w < 3000) begin @(negedge clk); w++; end
         check($sformatf("%s_tx%0d_avail", tag, i), 128'(txq.size() != 0), 128'h1);
         if (txq.size() == 0) return;
         check($sformatf("%s_tx%0d", tag, i), 128'(txq.pop_front()), 128'(exp_pt[8*i +: 8]));
      end
      begin
         int unsigned w = 0;
         while (tx_busy && w < 100) begin @(negedge clk); w++; end
         check({tag, "_tx_idle"}, 128'(tx_busy), 128'h0);
      end
   endtask

   task automatic send_ct(input string tag, input bit fixed);
      logic [127:0] exp_ct;
      logic [7:0]   b;
      exp_ct = '0;
      for (int i = 0; i < 16; i++) begin
         b = fixed ? 8'(8'h10 + i) : 8'($urandom);
         exp_ct[8*i +: 8] = b;
         send_rx(b);
      end
      check({tag, "_ct_valid"}, 128'(ct_valid), 128'h1);
      check({tag, "_ct_out"}, ct_out, exp_ct);
   endtask

   task automatic send_sense(input string tag, input int unsigned n, input bit fixed);
      logic [7:0] b;
      for (int i = 0; i < int'(n); i++) begin
         b = fixed ? 8'(8'h40 + i) : 8'($urandom);
         send_rx(b);
         check($sformatf("%s_sense%0d", tag, i), 128'({sense_valid, sense_index, sense_byte}),
               128'({1'b1, 9'(i), b}));
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_pt"}, pt_out, '0);
      check({tag, "_ct"}, ct_out, '0);
      check({tag, "_strobes"}, 128'({ct_valid, sense_valid, done, busy, timeout_err, ifc.uart_tx_enable}), '0);
      check({tag, "_sense"}, 128'({sense_index, sense_byte}), '0);
      check({tag, "_count_txd"}, 128'({trace_count, ifc.uart_data_to_tx}), '0);
   endtask

   task automatic run_full(input string tag, input bit fixed_first);
      logic [127:0] exp_pt;
      ct_pulses = 0;
      done_pulses = 0;
      txq.delete();
      model_run_start();
      cur_pt_in = fixed_first ? 128'h00112233445566778899aabbccddeeff : rand128();
      pt_in = cur_pt_in;
      pulse_start();
      for (int t = 0; t < int'(NT); t++) begin
         string tt;
         bit fx;
         tt = $sformatf("%s_t%0d", tag, t);
         fx = fixed_first && (t == 0);
         next_expected_pt(exp_pt);
         recv_tx_block(tt, exp_pt);
         check({tt, "_pt_out"}, pt_out, exp_pt);
         cur_pt_in = rand128();
         pt_in = cur_pt_in;
         send_ct(tt, fx);
         send_sense(tt, SB, fx);
         @(negedge clk);
         check({tt, "_trace_count"}, 128'(trace_count), 128'(t + 1));
      end
      repeat (3) @(negedge clk);
      check({tag, "_ct_pulses"}, 128'(ct_pulses), 128'(NT));
      check({tag, "_done_pulses"}, 128'(done_pulses), 128'h1);
      check({tag, "_busy_after"}, 128'(busy), 128'h0);
   endtask

   initial begin
      logic [127:0] exp_pt;
      int unsigned  k;
      ifc.uart_rx_ready = 1'b0;
      ifc.uart_data_from_rx = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_all_zero("reset");

      send_rx(8'haa);
      check("idle_rx_ignored", 128'({ct_valid, sense_valid, busy}), '0);
      check("idle_rx_ct", ct_out, '0);

      run_full("runA", 1'b1);

      // timeout run, with the UART holding ready high after each strobe
      hold_mode = 1'b1;
      txq.delete();
      model_run_start();
      cur_pt_in = rand128();
      pt_in = cur_pt_in;
      pulse_start();
      next_expected_pt(exp_pt);
      recv_tx_block("runB", exp_pt);
      hold_mode = 1'b0;
      send_ct("runB", 1'b0);
      send_sense("runB", 5, 1'b0);
      k = 0;
      do begin @(negedge clk); k++; end while (!timeout_err && k < 300);
      check("timeout_idle_cycles", 128'(k), 128'(TO));
      check("timeout_err_set", 128'(timeout_err), 128'h1);
      check("err_busy_low", 128'(busy), 128'h0);
      repeat (5) @(negedge clk);
      check("err_sticky", 128'(timeout_err), 128'h1);

      // restart from ERR, then abort with rst on sensor byte 20
      txq.delete();
      model_run_start();
      cur_pt_in = rand128();
      pt_in = cur_pt_in;
      pulse_start();
      check("restart_err_clear", 128'(timeout_err), 128'h0);
      check("restart_busy", 128'(busy), 128'h1);
      next_expected_pt(exp_pt);
      recv_tx_block("runC", exp_pt);
      send_ct("runC", 1'b0);
      send_sense("runC", 20, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      ifc.uart_rx_ready = 1'b1;
      ifc.uart_data_from_rx = 8'h5a;
      @(negedge clk);
      ifc.uart_rx_ready = 1'b0;
      check_all_zero("midrst");
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("midrst_idle", 128'({busy, sense_valid}), '0);

      run_full("runD", 1'b0);

      check("tx_strobe_spacing", 128'(tx_early), '0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/cpa_trace_host.md
# cpa_trace_host

Host-side initiator of the CPA capture UART protocol: per trace, sends a 16-byte plaintext, then collects the 16-byte ciphertext and the sensor trace bytes returned by the sensing target. It runs on a second iCE40 (or a loopback self-test build) between a UART core and the trace sink/logger. It repeats for a programmed number of traces and flags a stalled target with a timeout.

## Interface
- NUM_TRACES, 1000: traces per run (1..65535)
- SENSE_BYTES, 56: sensor bytes expected after each ciphertext (1..512)
- TIMEOUT_CYCLES, 24'd12_000_000: max idle clocks between received bytes
- LFSR_SEED, 128'h1: plaintext LFSR seed; 0 is replaced by 1
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  level; sampled in IDLE to begin a run
- pt_in  in  128  external plaintext (used only without CPA_HOST_LFSR_EN)
- uart_tx_ready  in  1  UART transmitter idle
- uart_tx_enable  out  1  one-cycle send strobe
- uart_data_to_tx  out  8  byte to send
- uart_rx_ready  in  1  one-cycle strobe, byte received
- uart_data_from_rx  in  8  received byte
- pt_out  out  128  plaintext of current trace
- ct_out  out  128  captured ciphertext
- ct_valid  out  1  one-cycle pulse, ct_out complete
- sense_byte  out  8  sensor byte
- sense_valid  out  1  one-cycle pulse per sensor byte
- sense_index  out  9  index of sense_byte within trace
- trace_count  out  16  completed traces
- busy  out  1  high outside IDLE/DONE/ERR
- done  out  1  one-cycle pulse at end of run
- timeout_err  out  1  sticky; cleared by rst or next start

## Operation
- States: IDLE, GEN_PT, SEND_PT, TX_WAIT, RECV_CT, RECV_SENSE, NEXT, DONE, ERR.
- IDLE: start=1 -> clear trace_count, timeout_err; go GEN_PT.
- GEN_PT: produce plaintext into pt_out; bytecount=0 -> SEND_PT.
- SEND_PT: when uart_tx_ready=1, drive uart_data_to_tx=pt_out[8*bytecount+:8], pulse uart_tx_enable, bytecount++ -> TX_WAIT. Byte 0 (bits 7:0) first.
- TX_WAIT: wait for uart_tx_ready=0, then =1; bytecount==16 -> RECV_CT (bytecount=0), else SEND_PT.
- RECV_CT: each uart_rx_ready stores byte at ct_out[8*bytecount+:8]; 16th byte -> ct_valid pulse, RECV_SENSE.
- RECV_SENSE: each uart_rx_ready -> sense_byte, sense_index=bytecount, sense_valid pulse; SENSE_BYTES-th byte -> NEXT.
- NEXT: trace_count++; trace_count==NUM_TRACES -> DONE, else GEN_PT.
- DONE: done pulse -> IDLE.
- Timeout: 24-bit counter reset on entry to RECV_CT and on every uart_rx_ready in RECV_CT/RECV_SENSE; reaching TIMEOUT_CYCLES -> ERR, timeout_err=1. ERR holds until start rises again (treated as a new run) or rst.
- uart_rx_ready outside RECV_CT/RECV_SENSE: ignored, byte dropped.
- uart_rx_ready and timeout terminal count in the same cycle: byte wins, counter clears.

## Timing
- Reset values: all outputs 0, state IDLE, LFSR=LFSR_SEED (or 1).
- ct_valid: one cycle after the strobe of ciphertext byte 15. sense_valid: one cycle after each RX strobe; data registered.
- uart_tx_enable never high on two consecutive cycles; minimum 2 cycles between strobes.
- done asserts the cycle after the final NEXT.
- rst mid-run: immediate return to IDLE; partial trace discarded, trace_count=0.

## Configuration
- CPA_HOST_LFSR_EN defined: GEN_PT lasts 128 cycles, stepping a 128-bit Fibonacci LFSR (taps 128,126,101,99) once per cycle; pt_out = LFSR state; pt_in ignored.
- Undefined: GEN_PT lasts 1 cycle; pt_out <= pt_in; no LFSR logic.

## Structure
- Shared package cpa_pkg: state encoding, AES_BLOCK_BYTES=16, default SENSE_BYTES=56, LFSR tap constants.
- One sub-module: cpa_pt_lfsr (128-bit LFSR, step/load ports), instantiated only under CPA_HOST_LFSR_EN.

## Test plan
- NUM_TRACES=1, pt_in=128'h00112233445566778899aabbccddeeff (no LFSR): TX bytes ff,ee,...,00 in order; respond 16 ct bytes 0x10..0x1f, 56 sense bytes 0x40.. -> ct_out=128'h1f1e..10, 56 sense_valid with index 0..55, done once.
- NUM_TRACES=3: trace_count 1,2,3; exactly 3 ct_valid pulses; busy low after done.
- TIMEOUT_CYCLES=100, stop after 5 sense bytes -> ERR and timeout_err=1 after 100 idle cycles; start -> timeout_err clears, new trace sent.
- uart_tx_ready held high for 10 cycles after a strobe -> no second strobe until ready drops and returns.
- LFSR_EN, LFSR_SEED=0 -> first pt_out equals 128 steps from seed 1; second differs.
- rst asserted during RECV_SENSE byte 20 -> all outputs 0 next cycle, IDLE.
